// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with dead-time between digits,
// double-buffered display data and leading-zero / per-digit blanking.
module seg_scan_ctrl #(
    parameter int ON_CYCLES   = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp,
    input  logic        lz_en,
    input  logic        load,
    output logic [3:0]  hex_sel,
    output logic        dp_out,
    output logic [3:0]  anodes,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    localparam int MAX_CYCLES = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic {ST_DEAD, ST_ON} state_t;

    state_t        state_q, state_d;
    logic [1:0]    digit_q, digit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          boundary;

    logic [15:0]   s_value_q, s_value_d;
    logic [3:0]    s_blank_q, s_blank_d;
    logic [3:0]    s_dp_q, s_dp_d;
    logic          s_lz_q, s_lz_d;
    logic          pending_q, pending_d;

    logic [15:0]   a_value_q, a_value_d;
    logic [3:0]    a_blank_q, a_blank_d;
    logic [3:0]    a_dp_q, a_dp_d;
    logic          a_lz_q, a_lz_d;

    logic [3:0]    anodes_q, anodes_d;
    logic [3:0]    hex_q, hex_d;
    logic          dp_q, dp_d;
    logic [1:0]    idx_q, idx_d;
    logic          fd_q, fd_d;

    logic [3:0]    supp;

    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        cnt_d    = cnt_q + 1'b1;
        boundary = 1'b0;
        case (state_q)
            ST_DEAD: begin
                if (cnt_q == CW'(DEAD_CYCLES - 1)) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == CW'(ON_CYCLES - 1)) begin
                    state_d  = ST_DEAD;
                    digit_d  = digit_q + 2'd1;
                    cnt_d    = '0;
                    boundary = (digit_q == 2'd3);
                end
            end
        endcase
    end

    // A load coinciding with the frame boundary lands in the shadow set and waits a frame.
    always_comb begin
        s_value_d = load ? value : s_value_q;
        s_blank_d = load ? blank : s_blank_q;
        s_dp_d    = load ? dp    : s_dp_q;
        s_lz_d    = load ? lz_en : s_lz_q;
        pending_d = load ? 1'b1 : (boundary ? 1'b0 : pending_q);
        a_value_d = a_value_q;
        a_blank_d = a_blank_q;
        a_dp_d    = a_dp_q;
        a_lz_d    = a_lz_q;
        if (boundary && pending_q) begin
            a_value_d = s_value_q;
            a_blank_d = s_blank_q;
            a_dp_d    = s_dp_q;
            a_lz_d    = s_lz_q;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_supp
        if (gi == 0) begin : g_first
            assign supp[gi] = a_blank_d[gi];
        end else begin : g_upper
            assign supp[gi] = a_blank_d[gi] | (a_lz_d & (a_value_d[15:4*gi] == '0));
        end
    end

    // Outputs are computed from next-state so they line up with the state they describe.
    always_comb begin
        anodes_d = 4'b1111;
        dp_d     = 1'b0;
        hex_d    = a_value_d[{digit_d, 2'b00} +: 4];
        idx_d    = digit_d;
        fd_d     = boundary;
        if (state_d == ST_ON && !supp[digit_d]) begin
            anodes_d = ~(4'b0001 << digit_d);
            dp_d     = a_dp_d[digit_d];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_DEAD;
            digit_q   <= 2'd0;
            cnt_q     <= '0;
            s_value_q <= '0;
            s_blank_q <= '0;
            s_dp_q    <= '0;
            s_lz_q    <= 1'b0;
            pending_q <= 1'b0;
            a_value_q <= '0;
            a_blank_q <= '0;
            a_dp_q    <= '0;
            a_lz_q    <= 1'b0;
            anodes_q  <= 4'b1111;
            hex_q     <= 4'd0;
            dp_q      <= 1'b0;
            idx_q     <= 2'd0;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            digit_q   <= digit_d;
            cnt_q     <= cnt_d;
            s_value_q <= s_value_d;
            s_blank_q <= s_blank_d;
            s_dp_q    <= s_dp_d;
            s_lz_q    <= s_lz_d;
            pending_q <= pending_d;
            a_value_q <= a_value_d;
            a_blank_q <= a_blank_d;
            a_dp_q    <= a_dp_d;
            a_lz_q    <= a_lz_d;
            anodes_q  <= anodes_d;
            hex_q     <= hex_d;
            dp_q      <= dp_d;
            idx_q     <= idx_d;
            fd_q      <= fd_d;
        end
    end

    assign anodes     = anodes_q;
    assign hex_sel    = hex_q;
    assign dp_out     = dp_q;
    assign digit_idx  = idx_q;
    assign frame_done = fd_q;

endmodule
